// File: rtl/demux_collect8_pkg.sv
// demux_collect8_pkg: shared constants, FSM state type and lane decode helper
// for the demux_collect8 lane collector.
package demux_collect8_pkg;

   localparam int unsigned LANES = 8;
   localparam int unsigned SEL_W = 3;
   localparam logic [LANES-1:0] FULL_MASK = 8'hFF;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   // One-hot decode of a lane index.
   function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
      logic [LANES-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux_lane_regs.sv
// demux_lane_regs: eight 1-bit lane registers plus a written-lane mask.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   wr_en             write one lane this cycle
//   wr_idx            lane index to write
//   wr_bit            value written to the lane
//   clear             clear all lanes and the mask (frame handed off)
//   bits, mask        current lane contents and written-lane mask
module demux_lane_regs
   import demux_collect8_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_idx,
   input  logic             wr_bit,
   input  logic             clear,
   output logic [LANES-1:0] bits,
   output logic [LANES-1:0] mask
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         bits <= '0;
         mask <= '0;
      end else if (wr_en) begin
         // Repeated writes to a lane overwrite the bit; the mask bit stays set.
         bits[wr_idx] <= wr_bit;
         mask[wr_idx] <= 1'b1;
      end
   end

endmodule

// File: rtl/demux_collect8.sv
// demux_collect8: steers a serial stream of tagged 1-bit samples into eight
// lanes, closes a frame on io_last or when every lane has been written, then
// presents the assembled word and written-lane mask under valid/ready.
// Parameter:
//   SEQ_MODE      0: lane = io_sel; 1: lane from an internal 0..7 counter
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   io_in         sample bit
//   io_sel        target lane (used only when SEQ_MODE = 0)
//   io_last       sample closes the frame
//   io_in_valid   sample present
//   io_in_ready   block can accept a sample (high in COLLECT only)
//   io_out_bits   assembled word, bit k = lane k (0 outside HOLD)
//   io_out_mask   bit k set if lane k written this frame (0 outside HOLD)
//   io_out_valid  frame available (high in HOLD only)
//   io_out_ready  downstream accepts the frame
module demux_collect8
   import demux_collect8_pkg::*;
#(
   parameter bit SEQ_MODE = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in,
   input  logic [SEL_W-1:0] io_sel,
   input  logic             io_last,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   output logic [LANES-1:0] io_out_bits,
   output logic [LANES-1:0] io_out_mask,
   output logic             io_out_valid,
   input  logic             io_out_ready
);

   state_e           state;
   logic [SEL_W-1:0] lane_cnt;
   logic [SEL_W-1:0] lane;
   logic [LANES-1:0] lane_bits;
   logic [LANES-1:0] lane_mask;
   logic             accept;
   logic             closing;
   logic             handoff;

   assign accept  = io_in_valid && (state == COLLECT);
   assign lane    = SEQ_MODE ? lane_cnt : io_sel;
   // Closing test uses the mask as it will be after this write.
   assign closing = accept && (io_last || ((lane_mask | lane_onehot(lane)) == FULL_MASK));
   assign handoff = (state == HOLD) && io_out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= COLLECT;
         lane_cnt <= '0;
      end else begin
         unique case (state)
            COLLECT: begin
               if (accept) lane_cnt <= lane_cnt + 1'b1;
               if (closing) state <= HOLD;
            end
            HOLD: begin
               if (io_out_ready) begin
                  state    <= COLLECT;
                  lane_cnt <= '0;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

   demux_lane_regs u_lane_regs (
      .clock  (clock),
      .reset  (reset),
      .wr_en  (accept),
      .wr_idx (lane),
      .wr_bit (io_in),
      .clear  (handoff),
      .bits   (lane_bits),
      .mask   (lane_mask)
   );

   // Outputs depend on registered state only; a partial frame stays hidden.
   assign io_in_ready  = (state == COLLECT);
   assign io_out_valid = (state == HOLD);
   assign io_out_bits  = (state == HOLD) ? lane_bits : '0;
   assign io_out_mask  = (state == HOLD) ? lane_mask : '0;

endmodule
